// File: rtl/pri_encode8_pkg.sv
// Shared definitions for the latching 8-line priority encoder.
//   NLINES    number of request lines
//   CODE_W    width of the granted-line code
//   state_e   handshake FSM states
package pri_encode8_pkg;

    localparam int unsigned NLINES = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRecover = 2'd2
    } state_e;

endpackage

// File: rtl/pri_encode8_prienc8.sv
// Combinational 8->3 priority encoder; line 0 (vector MSB) has the highest priority.
//   req_i  [0:7]  request vector, req_i[0] = line 0
//   idx_o  [0:2]  index of the lowest-numbered set line (0 when none set)
//   any_o         at least one line is set
module pri_encode8_prienc8
    import pri_encode8_pkg::*;
(
    input  logic [0:NLINES-1] req_i,
    output logic [0:CODE_W-1] idx_o,
    output logic              any_o
);

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        // Walk from the lowest priority upward so the lowest index overwrites last.
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = CODE_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_encode8.sv
// Latching 8-line priority encoder with valid/ack handshake.
// Collects requests, presents the highest-priority pending line as a code and holds it until ack.
//   clk      system clock
//   reset    synchronous active-low reset
//   req_in   [0:7] request lines, line 0 highest priority
//   enb      1 = new grants may be issued (requests accumulate regardless)
//   ack      consumer accepts the presented code
//   valid    code is presented
//   code     [0:2] index of the granted line
//   pending  [0:7] registered pending-request vector
module pri_encode8
    import pri_encode8_pkg::*;
#(
    // Bit i (MSB = line 0): 1 = edge-triggered and latched, 0 = level-sensitive.
    parameter logic [0:NLINES-1] EDGEMASK = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:NLINES-1] req_in,
    input  logic              enb,
    input  logic              ack,
    output logic              valid,
    output logic [0:CODE_W-1] code,
    output logic [0:NLINES-1] pending
);

    state_e            state_q;
    logic              valid_q;
    logic [0:CODE_W-1] code_q;
    logic [0:NLINES-1] last_q;
    logic [0:NLINES-1] pending_q;
    logic [0:NLINES-1] pending_d;

    logic [0:CODE_W-1] enc_idx;
    logic              enc_any;
    logic              grant_ack;

    pri_encode8_prienc8 u_prienc8 (
        .req_i (pending_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    assign grant_ack = (state_q == StGrant) && ack;

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NLINES; i++) begin
            if (EDGEMASK[i]) begin
                // A fresh edge in the same cycle as the clearing ack wins.
                pending_d[i] = (pending_q[i] && !(grant_ack && (code_q == CODE_W'(i))))
                               || (req_in[i] && !last_q[i]);
            end else begin
                pending_d[i] = req_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            code_q    <= '0;
            last_q    <= '0;
            pending_q <= '0;
        end else begin
            last_q    <= req_in;
            pending_q <= pending_d;
            unique case (state_q)
                StIdle: begin
                    if (enb && enc_any) begin
                        code_q  <= enc_idx;
                        valid_q <= 1'b1;
                        state_q <= StGrant;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                StGrant: begin
                    // Held until ack; later requests and enb=0 never preempt.
                    if (ack) begin
                        valid_q <= 1'b0;
                        state_q <= StRecover;
                    end
                end
                StRecover: begin
                    // Dead cycle lets a level requester drop its line.
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign valid   = valid_q;
    assign code    = code_q;
    assign pending = pending_q;

endmodule
